// File: rtl/fft_frame_ctrl_pkg.sv
// Shared types and helpers for the FFT front-end frame sequencer.
package fft_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PAD   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int INFLIGHT_W = 3;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fft_frame_ctrl_mode_fifo.sv
// 1-bit synchronous FIFO holding the IFFT mode of each frame in flight.
module fft_mode_fifo
  import fft_frame_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  din,
  output logic                  head,
  output logic [INFLIGHT_W-1:0] count
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0]         PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [PW-1:0]         PTR_ONE   = PW'(1);
  localparam logic [INFLIGHT_W-1:0] CNT_FULL  = INFLIGHT_W'(DEPTH);
  localparam logic [INFLIGHT_W-1:0] CNT_ONE   = INFLIGHT_W'(1);
  localparam logic [INFLIGHT_W-1:0] CNT_ZERO  = INFLIGHT_W'(0);

  logic [DEPTH-1:0]      mem_q, mem_d;
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [INFLIGHT_W-1:0] count_q, count_d;
  logic                  pop_eff, push_eff;

  // Pointer/count update; a push into a full FIFO is legal only alongside a pop.
  always_comb begin
    pop_eff  = pop && (count_q != CNT_ZERO);
    push_eff = push && ((count_q != CNT_FULL) || pop_eff);
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    count_d  = count_q;
    if (push_eff) begin
      mem_d[wr_q] = din;
      wr_d        = (wr_q == PTR_LAST) ? {PW{1'b0}} : wr_q + PTR_ONE;
    end else begin
      wr_d = wr_q;
    end
    if (pop_eff) begin
      rd_d = (rd_q == PTR_LAST) ? {PW{1'b0}} : rd_q + PTR_ONE;
    end else begin
      rd_d = rd_q;
    end
    if (push_eff && !pop_eff) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_eff && !push_eff) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= {DEPTH{1'b0}};
      wr_q    <= {PW{1'b0}};
      rd_q    <= {PW{1'b0}};
      count_q <= CNT_ZERO;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Front-end sequencer for the radix-2 stage chain: frame addressing, IFFT conjugation,
// flush zero-padding, in-flight limiting and last-stage completion/sequence monitoring.
module fft_frame_ctrl
  import fft_frame_ctrl_pkg::*;
#(
  parameter int TOTAL_STAGE_P = 10,
  parameter int MULT_WIDTH_P  = 18,
  parameter int MAX_INFLIGHT  = 2
) (
  input  logic                         iclk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         cfg_inv,
  input  logic                         flush,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [2*MULT_WIDTH_P-1:0]    s_data,
  output logic                         oen,
  output logic [TOTAL_STAGE_P-1:0]     oaddr,
  output logic [2*MULT_WIDTH_P-1:0]    odata,
  input  logic                         pipe_oen,
  input  logic [TOTAL_STAGE_P-1:0]     pipe_oaddr,
  output logic                         frame_done,
  output logic                         frame_inv,
  output logic [2:0]                   inflight,
  output logic                         busy,
  output logic                         err_seq
);

  localparam int TSP = TOTAL_STAGE_P;
  localparam int MW  = MULT_WIDTH_P;
  localparam logic [TSP-1:0]  ADDR_LAST = {TSP{1'b1}};
  localparam logic [TSP-1:0]  ADDR_ZERO = {TSP{1'b0}};
  localparam logic [TSP-1:0]  ADDR_ONE  = TSP'(1);
  localparam logic [2:0]      INF_MAX   = 3'(MAX_INFLIGHT);

  // Saturating conjugate: the most negative imag value has no positive twin.
  function automatic logic [2*MW-1:0] conj_sat(input logic [2*MW-1:0] d);
    logic [MW-1:0] im;
    logic [MW-1:0] neg;
    im = d[MW-1:0];
    if (im == {1'b1, {(MW-1){1'b0}}}) begin
      neg = {1'b0, {(MW-1){1'b1}}};
    end else begin
      neg = ~im + {{(MW-1){1'b0}}, 1'b1};
    end
    return {d[2*MW-1:MW], neg};
  endfunction

  state_e              state_q, state_d;
  logic [TSP-1:0]      addr_q, addr_d;
  logic                mode_q, mode_d;
  logic                oen_q, oen_d;
  logic [TSP-1:0]      oaddr_q, oaddr_d;
  logic [2*MW-1:0]     odata_q, odata_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_inv_q, frame_inv_d;
  logic                err_seq_q, err_seq_d;
  logic [TSP-1:0]      exp_addr_q, exp_addr_d;

  logic                accept, pad, start, cur_mode, complete, pop;
  logic                fifo_head;
  logic [2:0]          fifo_count;

  assign inflight = fifo_count;
  assign s_ready  = (state_q == ST_LOAD) && !((addr_q == ADDR_ZERO) && (inflight == INF_MAX)) && !flush;
  assign busy     = (state_q != ST_IDLE) || (inflight != 3'd0);

  // Datapath, frame bookkeeping and completion/sequence monitoring.
  always_comb begin
    accept   = s_valid && s_ready;
    pad      = (state_q == ST_PAD);
    start    = (accept || pad) && (addr_q == ADDR_ZERO);
    cur_mode = (addr_q == ADDR_ZERO) ? cfg_inv : mode_q;
    complete = pipe_oen && (pipe_oaddr == ADDR_LAST);
    pop      = complete && (inflight != 3'd0);

    mode_d       = start ? cur_mode : mode_q;
    addr_d       = (accept || pad) ? addr_q + ADDR_ONE : addr_q;
    frame_done_d = pop;
    frame_inv_d  = pop ? fifo_head : 1'b0;

    if (accept) begin
      oen_d   = 1'b1;
      oaddr_d = addr_q;
      odata_d = cur_mode ? conj_sat(s_data) : s_data;
    end else if (pad) begin
      oen_d   = 1'b1;
      oaddr_d = addr_q;
      odata_d = {(2*MW){1'b0}};
    end else begin
      oen_d   = 1'b0;
      oaddr_d = ADDR_LAST;
      odata_d = {(2*MW){1'b0}};
    end

    if (pipe_oen) begin
      err_seq_d  = err_seq_q || (pipe_oaddr != exp_addr_q) || (complete && (inflight == 3'd0));
      exp_addr_d = pipe_oaddr + ADDR_ONE;
    end else begin
      err_seq_d  = err_seq_q;
      exp_addr_d = exp_addr_q;
    end
  end

  // Next-state logic; an accept at addr 0 with en low keeps us in LOAD for that frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
        else    state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (flush && (addr_q != ADDR_ZERO))                  state_d = ST_PAD;
        else if (!en && (addr_q == ADDR_ZERO) && !accept)    state_d = ST_DRAIN;
        else                                                 state_d = ST_LOAD;
      end
      ST_PAD: begin
        if (addr_q == ADDR_LAST) state_d = ST_LOAD;
        else                     state_d = ST_PAD;
      end
      ST_DRAIN: begin
        if (en)                     state_d = ST_LOAD;
        else if (inflight == 3'd0)  state_d = ST_IDLE;
        else                        state_d = ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge iclk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= ADDR_ZERO;
      mode_q       <= 1'b0;
      oen_q        <= 1'b0;
      oaddr_q      <= ADDR_LAST;
      odata_q      <= {(2*MW){1'b0}};
      frame_done_q <= 1'b0;
      frame_inv_q  <= 1'b0;
      err_seq_q    <= 1'b0;
      exp_addr_q   <= ADDR_ZERO;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      mode_q       <= mode_d;
      oen_q        <= oen_d;
      oaddr_q      <= oaddr_d;
      odata_q      <= odata_d;
      frame_done_q <= frame_done_d;
      frame_inv_q  <= frame_inv_d;
      err_seq_q    <= err_seq_d;
      exp_addr_q   <= exp_addr_d;
    end
  end

  fft_mode_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_mode_fifo (
    .clk   (iclk),
    .rst   (rst),
    .push  (start),
    .pop   (pop),
    .din   (cur_mode),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign oen        = oen_q;
  assign oaddr      = oaddr_q;
  assign odata      = odata_q;
  assign frame_done = frame_done_q;
  assign frame_inv  = frame_inv_q;
  assign err_seq    = err_seq_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl with N=16, 18-bit components, two frames in flight.
module tb_fft_frame_ctrl;

  localparam int TSP  = 4;
  localparam int MW   = 18;
  localparam int MAXI = 2;
  localparam int N    = 16;

  logic            iclk = 1'b0;
  logic            rst, en, cfg_inv, flush, s_valid, s_ready;
  logic [2*MW-1:0] s_data;
  logic            oen;
  logic [TSP-1:0]  oaddr;
  logic [2*MW-1:0] odata;
  logic            pipe_oen;
  logic [TSP-1:0]  pipe_oaddr;
  logic            frame_done, frame_inv, busy, err_seq;
  logic [2:0]      inflight;

  int n_cmp = 0;
  int n_bad = 0;
  int m_inflight = 0;
  bit exp_modes[$];
  bit cur_mode_m;

  fft_frame_ctrl #(.TOTAL_STAGE_P(TSP), .MULT_WIDTH_P(MW), .MAX_INFLIGHT(MAXI)) dut (
    .iclk(iclk), .rst(rst), .en(en), .cfg_inv(cfg_inv), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .oen(oen), .oaddr(oaddr), .odata(odata),
    .pipe_oen(pipe_oen), .pipe_oaddr(pipe_oaddr),
    .frame_done(frame_done), .frame_inv(frame_inv), .inflight(inflight),
    .busy(busy), .err_seq(err_seq)
  );

  always #5 iclk = ~iclk;

  // Reference conjugation with plain integer arithmetic and clamping.
  function automatic logic [2*MW-1:0] ref_out(input logic [2*MW-1:0] d, input bit inv);
    logic [MW-1:0] im_bits;
    int            im;
    im_bits = d[MW-1:0];
    im = int'($signed(im_bits));
    if (inv) begin
      im = -im;
      if (im > (1 << (MW-1)) - 1) im = (1 << (MW-1)) - 1;
    end
    return {d[2*MW-1:MW], im[MW-1:0]};
  endfunction

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic drive_beat(input logic [2*MW-1:0] d, input bit inv, output bit rdy);
    s_valid = 1'b1; s_data = d; cfg_inv = inv;
    #1;
    rdy = s_ready;
    @(posedge iclk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic pipe_beat(input int a);
    pipe_oen = 1'b1; pipe_oaddr = 4'(a);
    step();
    pipe_oen = 1'b0;
  endtask

  task automatic stream_samples(input int first, input int last, input bit inv, input int toggle_at);
    bit rdy;
    bit inv_now;
    logic [2*MW-1:0] d, exp_d;
    for (int i = first; i <= last; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step();
        n_cmp++; if (oen !== 1'b0 || oaddr !== 4'hF || odata !== 36'd0) begin n_bad++; $display("FAIL idle_out i=%0d got oen=%b oaddr=%h odata=%h exp 0/f/0", i, oen, oaddr, odata); end
      end
      d = 36'({$urandom(), $urandom()});
      if (i == 3) d[MW-1:0] = 18'h20000;
      inv_now = (i >= toggle_at) ? ~inv : inv;
      if (i == 0) begin cur_mode_m = inv_now; exp_modes.push_back(inv_now); m_inflight++; end
      exp_d = ref_out(d, cur_mode_m);
      drive_beat(d, inv_now, rdy);
      n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, rdy); end
      n_cmp++; if (oen !== 1'b1 || oaddr !== 4'(i)) begin n_bad++; $display("FAIL stream_addr i=%0d got oen=%b oaddr=%0d exp 1/%0d", i, oen, oaddr, i); end
      n_cmp++; if (odata !== exp_d) begin n_bad++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, odata, exp_d); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; flush = 1'b0; s_valid = 1'b0; cfg_inv = 1'b0; s_data = '0;
    pipe_oen = 1'b0; pipe_oaddr = '0;
    step(); step();
    m_inflight = 0; exp_modes.delete();
    n_cmp++; if (oen !== 1'b0 || oaddr !== 4'hF || odata !== 36'd0) begin n_bad++; $display("FAIL reset_out got oen=%b oaddr=%h odata=%h exp 0/f/0", oen, oaddr, odata); end
    n_cmp++; if (frame_done !== 1'b0 || frame_inv !== 1'b0 || err_seq !== 1'b0) begin n_bad++; $display("FAIL reset_flags got done=%b inv=%b err=%b exp 0/0/0", frame_done, frame_inv, err_seq); end
    n_cmp++; if (inflight !== 3'd0 || s_ready !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl got inflight=%0d ready=%b busy=%b exp 0/0/0", inflight, s_ready, busy); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    en = 1'b1;
    step();
    stream_samples(0, N-1, 1'b0, N);
    n_cmp++; if (inflight !== 3'(m_inflight)) begin n_bad++; $display("FAIL stream_inflight got=%0d exp=%0d", inflight, m_inflight); end
  endtask

  task automatic test_conj();
    stream_samples(0, N-1, 1'b1, 5);
    n_cmp++; if (inflight !== 3'(m_inflight)) begin n_bad++; $display("FAIL conj_inflight got=%0d exp=%0d", inflight, m_inflight); end
  endtask

  task automatic test_stall();
    bit m;
    s_valid = 1'b1; s_data = 36'({$urandom(), $urandom()}); cfg_inv = 1'b0;
    for (int i = 0; i < N-1; i++) begin
      #1;
      n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", i, s_ready); end
      pipe_beat(i);
      n_cmp++; if (oen !== 1'b0) begin n_bad++; $display("FAIL stall_oen cyc=%0d got=%b exp=0", i, oen); end
    end
    pipe_beat(N-1);
    s_valid = 1'b0;
    m = exp_modes.pop_front(); m_inflight--;
    #1;
    n_cmp++; if (frame_done !== 1'b1 || frame_inv !== m) begin n_bad++; $display("FAIL stall_done got done=%b inv=%b exp 1/%b", frame_done, frame_inv, m); end
    n_cmp++; if (inflight !== 3'(m_inflight) || s_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release got inflight=%0d ready=%b exp %0d/1", inflight, s_ready, m_inflight); end
    step();
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL done_pulse got=%b exp=0", frame_done); end
  endtask

  task automatic test_flush();
    bit m;
    stream_samples(0, 5, 1'b0, N);
    flush = 1'b1;
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready got=%b exp=0", s_ready); end
    step();
    flush = 1'b0;
    n_cmp++; if (oen !== 1'b0) begin n_bad++; $display("FAIL flush_edge_oen got=%b exp=0", oen); end
    for (int k = 6; k < N; k++) begin
      #1;
      n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL pad_ready k=%0d got=%b exp=0", k, s_ready); end
      step();
      n_cmp++; if (oen !== 1'b1 || oaddr !== 4'(k) || odata !== 36'd0) begin n_bad++; $display("FAIL pad_out k=%0d got oen=%b oaddr=%0d odata=%h exp 1/%0d/0", k, oen, oaddr, odata, k); end
    end
    step();
    n_cmp++; if (oen !== 1'b0) begin n_bad++; $display("FAIL pad_end_oen got=%b exp=0", oen); end
    for (int i = 0; i < N; i++) pipe_beat(i);
    m = exp_modes.pop_front(); m_inflight--;
    n_cmp++; if (frame_done !== 1'b1 || frame_inv !== m) begin n_bad++; $display("FAIL flush_done got done=%b inv=%b exp 1/%b", frame_done, frame_inv, m); end
    n_cmp++; if (inflight !== 3'(m_inflight) || s_ready !== 1'b1) begin n_bad++; $display("FAIL flush_reload got inflight=%0d ready=%b exp %0d/1", inflight, s_ready, m_inflight); end
  endtask

  task automatic test_back_to_back();
    bit m, rdy;
    logic [2*MW-1:0] d, exp_d;
    for (int i = 0; i < N-1; i++) pipe_beat(i);
    d = 36'({$urandom(), $urandom()});
    m = exp_modes.pop_front();
    cur_mode_m = 1'b1; exp_modes.push_back(1'b1);
    exp_d = ref_out(d, 1'b1);
    pipe_oen = 1'b1; pipe_oaddr = 4'(N-1);
    drive_beat(d, 1'b1, rdy);
    pipe_oen = 1'b0;
    n_cmp++; if (rdy !== 1'b1 || frame_done !== 1'b1 || frame_inv !== m) begin n_bad++; $display("FAIL b2b_done got ready=%b done=%b inv=%b exp 1/1/%b", rdy, frame_done, frame_inv, m); end
    n_cmp++; if (inflight !== 3'(m_inflight)) begin n_bad++; $display("FAIL b2b_inflight got=%0d exp=%0d", inflight, m_inflight); end
    n_cmp++; if (oen !== 1'b1 || oaddr !== 4'd0 || odata !== exp_d) begin n_bad++; $display("FAIL b2b_out got oen=%b oaddr=%0d odata=%h exp 1/0/%h", oen, oaddr, odata, exp_d); end
    stream_samples(1, N-1, 1'b1, N);
    for (int i = 0; i < N; i++) pipe_beat(i);
    m = exp_modes.pop_front(); m_inflight--;
    n_cmp++; if (frame_done !== 1'b1 || frame_inv !== m || inflight !== 3'(m_inflight)) begin n_bad++; $display("FAIL b2b_last got done=%b inv=%b inflight=%0d exp 1/%b/%0d", frame_done, frame_inv, inflight, m, m_inflight); end
  endtask

  task automatic test_err_drain();
    int seq[5] = '{0, 1, 2, 3, 5};
    for (int i = 0; i < 5; i++) begin
      pipe_beat(seq[i]);
      n_cmp++; if (err_seq !== (i == 4)) begin n_bad++; $display("FAIL err_seq beat=%0d got=%b exp=%b", seq[i], err_seq, (i == 4)); end
    end
    step(); step();
    n_cmp++; if (err_seq !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b exp=1", err_seq); end
    en = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b1 || s_ready !== 1'b0) begin n_bad++; $display("FAIL drain_state got busy=%b ready=%b exp 1/0", busy, s_ready); end
    step();
    n_cmp++; if (busy !== 1'b0 || err_seq !== 1'b1) begin n_bad++; $display("FAIL drain_idle got busy=%b err=%b exp 0/1", busy, err_seq); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (err_seq !== 1'b0) begin n_bad++; $display("FAIL err_clear got=%b exp=0", err_seq); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_conj();
    test_stall();
    test_flush();
    test_back_to_back();
    test_err_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
